// File: rtl/of_ctrl_pkg.sv
// Shared definitions for the operand-fetch interlock: instruction field
// positions, the link register, stage indices and the tag-pipe entry type.
package of_ctrl_pkg;

  // MSB of each 4-bit register field inside the 32-bit instruction word
  localparam int RD_MSB  = 25;
  localparam int RS1_MSB = 21;
  localparam int RS2_MSB = 17;

  // Link register: written by call, read by ret
  localparam logic [3:0] RA_REG = 4'd15;

  // Positions of the in-flight stages inside the tag pipe
  typedef enum logic [1:0] {
    ST_EX = 2'd0,
    ST_MA = 2'd1,
    ST_RW = 2'd2
  } stage_e;

  // One in-flight destination: valid flag plus register number
  typedef struct packed {
    logic       v;
    logic [3:0] tag;
  } tag_entry_t;

  // True when a pending writer matches either consumed source operand
  function automatic logic src_match(tag_entry_t e, logic used1, logic [3:0] src1,
                                     logic used2, logic [3:0] src2);
    return e.v & ((used1 & (e.tag == src1)) | (used2 & (e.tag == src2)));
  endfunction

endpackage

// File: rtl/hz_tag_pipe.sv
// Three-entry destination-tag shift register covering EX, MA and RW.
// Holds everything while the back end is frozen, otherwise shifts one
// stage per cycle and loads EX with the issuing destination or a bubble.
module hz_tag_pipe
  import of_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_i,
  input  logic        ins_v_i,
  input  logic [3:0]  ins_tag_i,
  output tag_entry_t  ex_o,
  output tag_entry_t  ma_o,
  output tag_entry_t  rw_o,
  output logic [15:0] busy_vec_o
);

  tag_entry_t stage_q [3];
  tag_entry_t stage_d [3];

  // Next state: hold on freeze, else advance and insert the new EX entry
  always_comb begin
    stage_d = stage_q;
    if (!hold_i) begin
      stage_d[ST_RW]     = stage_q[ST_MA];
      stage_d[ST_MA]     = stage_q[ST_EX];
      stage_d[ST_EX].v   = ins_v_i;
      stage_d[ST_EX].tag = ins_v_i ? ins_tag_i : 4'd0;
    end
  end

  // Tag storage; reset abandons every pending writer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign ex_o = stage_q[ST_EX];
  assign ma_o = stage_q[ST_MA];
  assign rw_o = stage_q[ST_RW];

  // One-hot decode of every valid pending destination, RW included
  for (genvar gi = 0; gi < 16; gi++) begin : g_busy
    assign busy_vec_o[gi] = (stage_q[0].v & (stage_q[0].tag == 4'(gi)))
                          | (stage_q[1].v & (stage_q[1].tag == 4'(gi)))
                          | (stage_q[2].v & (stage_q[2].tag == 4'(gi)));
  end

endmodule

// File: rtl/of_hazard_interlock.sv
// Operand-fetch interlock for the non-forwarding 5-stage core. Decodes the
// OF sources/destination, stalls on pending writers, squashes on taken
// branches from EX and counts hazard-stall and flush cycles.
module of_hazard_interlock
  import of_ctrl_pkg::*;
#(
  parameter bit         WB_BYPASS = 1'b1,
  parameter int         CNT_W     = 16,
  parameter logic [3:0] RA_REG    = of_ctrl_pkg::RA_REG
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             of_valid,
  input  logic [31:0]      of_instr,
  input  logic             of_is_st,
  input  logic             of_is_ret,
  input  logic             of_is_imm,
  input  logic             of_is_wb,
  input  logic             of_is_call,
  input  logic             of_use_rs1,
  input  logic             ex_branch_taken,
  input  logic             stall_ext,
  output logic             of_stall,
  output logic             issue_valid,
  output logic             flush_if_of,
  output logic [15:0]      busy_vec,
  output logic [CNT_W-1:0] hazard_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [3:0]       src1, src2, dest_tag;
  logic             used1, used2, dest_v;
  logic             hazard, flush, hz_stall;
  tag_entry_t       ex_e, ma_e, rw_e;
  logic [CNT_W-1:0] hazard_cnt_q, hazard_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             unused_instr_bits;

  // Source operands: ret reads the link register, stores read rd as data
  assign src1  = of_is_ret ? RA_REG : of_instr[RS1_MSB -: 4];
  assign used1 = of_use_rs1 | of_is_ret;
  assign src2  = of_is_st ? of_instr[RD_MSB -: 4] : of_instr[RS2_MSB -: 4];
  assign used2 = of_is_st | ~of_is_imm;

  assign unused_instr_bits = ^{of_instr[31:26], of_instr[13:0]};

  // Destination decode: call writes the link register, otherwise rd if wb
  always_comb begin
    dest_v   = 1'b0;
    dest_tag = 4'd0;
    if (of_is_call) begin
      dest_v   = 1'b1;
      dest_tag = RA_REG;
    end else if (of_is_wb) begin
      dest_v   = 1'b1;
      dest_tag = of_instr[RD_MSB -: 4];
    end
  end

  // Hazard against older writers; RW only counts without write-then-read
  always_comb begin
    hazard = src_match(ex_e, used1, src1, used2, src2)
           | src_match(ma_e, used1, src1, used2, src2);
    if (!WB_BYPASS) begin
      hazard = hazard | src_match(rw_e, used1, src1, used2, src2);
    end
    hazard = hazard & of_valid;
  end

  // Priority: back-end freeze over flush over data hazard. Reset forces the
  // issue/flush controls idle so nothing is launched while held.
  assign flush       = ex_branch_taken & ~stall_ext & rst_n;
  assign hz_stall    = hazard & ~flush & ~stall_ext;
  assign flush_if_of = flush;
  assign issue_valid = of_valid & ~hazard & ~flush & ~stall_ext & rst_n;
  assign of_stall    = stall_ext | (hazard & ~flush);

  hz_tag_pipe u_tag_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .hold_i     (stall_ext),
    .ins_v_i    (issue_valid & dest_v),
    .ins_tag_i  (dest_tag),
    .ex_o       (ex_e),
    .ma_o       (ma_e),
    .rw_o       (rw_e),
    .busy_vec_o (busy_vec)
  );

  assign hazard_cnt_d = (hz_stall && (hazard_cnt_q != '1)) ? hazard_cnt_q + CNT_W'(1) : hazard_cnt_q;
  assign flush_cnt_d  = (flush && (flush_cnt_q != '1)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;

  // Saturating statistics counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hazard_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      hazard_cnt_q <= hazard_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign hazard_cnt = hazard_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_of_hazard_interlock.sv
// Directed plus randomized bench for of_hazard_interlock. Two instances run
// side by side on the same stimulus, one without and one with write-back
// bypass, each compared against a history-based model of in-flight writers.
module tb_of_hazard_interlock;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        of_valid = 1'b0, of_is_st = 1'b0, of_is_ret = 1'b0, of_is_imm = 1'b0;
  logic        of_is_wb = 1'b0, of_is_call = 1'b0, of_use_rs1 = 1'b0;
  logic        ex_branch_taken = 1'b0, stall_ext = 1'b0;
  logic [31:0] of_instr = 32'd0;

  logic        of_stall_w [2];
  logic        issue_w    [2];
  logic        flush_w    [2];
  logic [15:0] busy_w     [2];
  logic [15:0] hcnt_w     [2];
  logic [15:0] fcnt_w     [2];

  int checks = 0;
  int errors = 0;

  // Model: per instance, destinations of the last three launches (index 0 =
  // youngest, -1 = nothing), plus the statistics counts.
  int hist [2][3];
  int hc   [2];
  int fc   [2];

  always #5 clk = ~clk;

  of_hazard_interlock #(.WB_BYPASS(1'b0), .CNT_W(16)) dut_nb (
    .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_instr(of_instr),
    .of_is_st(of_is_st), .of_is_ret(of_is_ret), .of_is_imm(of_is_imm),
    .of_is_wb(of_is_wb), .of_is_call(of_is_call), .of_use_rs1(of_use_rs1),
    .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
    .of_stall(of_stall_w[0]), .issue_valid(issue_w[0]), .flush_if_of(flush_w[0]),
    .busy_vec(busy_w[0]), .hazard_cnt(hcnt_w[0]), .flush_cnt(fcnt_w[0])
  );

  of_hazard_interlock #(.WB_BYPASS(1'b1), .CNT_W(16)) dut_bp (
    .clk(clk), .rst_n(rst_n), .of_valid(of_valid), .of_instr(of_instr),
    .of_is_st(of_is_st), .of_is_ret(of_is_ret), .of_is_imm(of_is_imm),
    .of_is_wb(of_is_wb), .of_is_call(of_is_call), .of_use_rs1(of_use_rs1),
    .ex_branch_taken(ex_branch_taken), .stall_ext(stall_ext),
    .of_stall(of_stall_w[1]), .issue_valid(issue_w[1]), .flush_if_of(flush_w[1]),
    .busy_vec(busy_w[1]), .hazard_cnt(hcnt_w[1]), .flush_cnt(fcnt_w[1])
  );

  task automatic chk(string name, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(int rd, int rs1, int rs2);
    logic [31:0] w;
    w = $urandom;
    w[25:22] = 4'(rd);
    w[21:18] = 4'(rs1);
    w[17:14] = 4'(rs2);
    return w;
  endfunction

  task automatic set_in(logic v, logic [31:0] ins, logic wb, logic call, logic ret,
                        logic st, logic imm, logic u1, logic br, logic sx);
    of_valid = v; of_instr = ins; of_is_wb = wb; of_is_call = call;
    of_is_ret = ret; of_is_st = st; of_is_imm = imm; of_use_rs1 = u1;
    ex_branch_taken = br; stall_ext = sx;
  endtask

  // Register-register ALU op: rd <- rs1 op rs2
  task automatic alu(int rd, int rs1, int rs2);
    set_in(1'b1, mk(rd, rs1, rs2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int a = 0; a < 3; a++) hist[k][a] = -1;
      hc[k] = 0;
      fc[k] = 0;
    end
  endtask

  // One clock of a transaction: inputs already driven; check at the falling
  // edge, then advance the model across the rising edge.
  task automatic step(string nm);
    logic e_iss [2];
    logic e_hz  [2];
    logic e_fl  [2];
    int   e_dest;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      int s1, s2, lim;
      logic u1, u2, haz, fl, iss, stl;
      logic [15:0] busy;
      s1  = of_is_ret ? 15 : int'(of_instr[21:18]);
      u1  = of_use_rs1 | of_is_ret;
      s2  = of_is_st ? int'(of_instr[25:22]) : int'(of_instr[17:14]);
      u2  = of_is_st | ~of_is_imm;
      lim = (k == 1) ? 2 : 3;
      haz = 1'b0;
      for (int a = 0; a < lim; a++) begin
        if (hist[k][a] >= 0 && ((u1 && hist[k][a] == s1) || (u2 && hist[k][a] == s2)))
          haz = 1'b1;
      end
      haz  = haz & of_valid;
      fl   = ex_branch_taken & ~stall_ext & rst_n;
      iss  = of_valid & ~haz & ~fl & ~stall_ext & rst_n;
      stl  = stall_ext | (haz & ~fl);
      busy = 16'd0;
      for (int a = 0; a < 3; a++) begin
        if (hist[k][a] >= 0) busy = busy | (16'd1 << hist[k][a]);
      end
      chk($sformatf("%s/bp%0d/of_stall", nm, k), 16'(of_stall_w[k]), 16'(stl));
      chk($sformatf("%s/bp%0d/issue_valid", nm, k), 16'(issue_w[k]), 16'(iss));
      chk($sformatf("%s/bp%0d/flush_if_of", nm, k), 16'(flush_w[k]), 16'(fl));
      chk($sformatf("%s/bp%0d/busy_vec", nm, k), busy_w[k], busy);
      chk($sformatf("%s/bp%0d/hazard_cnt", nm, k), hcnt_w[k], 16'(hc[k]));
      chk($sformatf("%s/bp%0d/flush_cnt", nm, k), fcnt_w[k], 16'(fc[k]));
      e_iss[k] = iss;
      e_hz[k]  = haz & ~fl & ~stall_ext;
      e_fl[k]  = fl;
    end
    $display("[%0t] %s stall=%b/%b issue=%b/%b flush=%b busy=%h/%h", $time, nm,
             of_stall_w[0], of_stall_w[1], issue_w[0], issue_w[1], flush_w[0],
             busy_w[0], busy_w[1]);
    e_dest = of_is_call ? 15 : (of_is_wb ? int'(of_instr[25:22]) : -1);
    @(posedge clk);
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (!stall_ext) begin
          hist[k][2] = hist[k][1];
          hist[k][1] = hist[k][0];
          hist[k][0] = e_iss[k] ? e_dest : -1;
        end
        if (e_hz[k] && hc[k] < 65535) hc[k]++;
        if (e_fl[k] && fc[k] < 65535) fc[k]++;
      end
    end
    #1;
  endtask

  task automatic do_reset(string nm);
    set_in(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0;
    model_reset();
    step(nm);
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    #1;
    do_reset("reset");

    // Back-to-back RAW on r1
    alu(1, 2, 3);
    step("raw_i1");
    alu(4, 1, 5);
    for (int i = 0; i < 4; i++) step("raw_i2");
    chk("raw/bp0/hazard_cnt_total", hcnt_w[0], 16'd3);
    chk("raw/bp1/hazard_cnt_total", hcnt_w[1], 16'd2);

    // call then ret on the link register
    do_reset("rst_call");
    set_in(1'b1, mk(0, 0, 0), 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("call");
    chk("call/bp1/busy_ra", busy_w[1], 16'h8000);
    set_in(1'b1, mk(0, 0, 0), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("ret");
    chk("ret/bp1/hazard_cnt_total", hcnt_w[1], 16'd2);

    // Hazarded OF instruction squashed by a taken branch
    do_reset("rst_flush");
    alu(1, 2, 3);
    step("fl_i1");
    set_in(1'b1, mk(4, 1, 5), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("fl_br");
    chk("flush/bp0/flush_cnt", fcnt_w[0], 16'd1);
    chk("flush/bp0/busy_ex_bubble", busy_w[0], 16'h0002);
    chk("flush/bp0/hazard_cnt", hcnt_w[0], 16'd0);

    // Back-end freeze with three writers in flight
    do_reset("rst_freeze");
    alu(1, 8, 9); step("fz_w1");
    alu(2, 8, 9); step("fz_w2");
    alu(3, 8, 9); step("fz_w3");
    set_in(1'b1, mk(5, 1, 2), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step("fz_hold");
    chk("freeze/bp0/busy_held", busy_w[0], 16'h000E);
    chk("freeze/bp1/busy_held", busy_w[1], 16'h000E);
    chk("freeze/bp0/hazard_cnt", hcnt_w[0], 16'd0);
    stall_ext = 1'b0;
    for (int i = 0; i < 4; i++) step("fz_drain");

    // Reset in the middle of a hazard stall
    do_reset("rst_mid0");
    alu(1, 2, 3); step("mid_i1");
    alu(4, 1, 5); step("mid_i2");
    do_reset("rst_mid");
    alu(6, 1, 1);
    #1;
    chk("mid/bp0/issue_first", 16'(issue_w[0]), 16'd1);
    chk("mid/bp0/busy_clear", busy_w[0], 16'd0);
    chk("mid/bp0/hazard_cnt_clear", hcnt_w[0], 16'd0);
    step("mid_add");

    // Randomized traffic on a small register set to provoke hazards
    do_reset("rst_rand");
    for (int n = 0; n < 400; n++) begin
      int rd, r1, r2;
      if ($urandom_range(0, 199) == 0) begin
        do_reset("rand_rst");
      end else begin
        rd = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
        r1 = ($urandom_range(0, 9) == 0) ? 15 : int'($urandom_range(0, 3));
        r2 = int'($urandom_range(0, 3));
        set_in($urandom_range(0, 7) != 0, mk(rd, r1, r2),
               1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
               $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               $urandom_range(0, 9) == 0, $urandom_range(0, 6) == 0);
        step("rand");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
